// File: rtl/seg_mux_display_if.sv
// seg_mux_display_if: value/control bus from the game FSM and segment/digit pins toward the IO pads.
interface seg_mux_display_if #(
    parameter int DIGITS = 2
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_mask;
    logic                load;
    logic                blank_lz;
    logic [3:0]          brightness;
    logic                seginv;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   dig;
    logic                frame_done;
    modport master (
        output value, dp_mask, load, blank_lz, brightness, seginv,
        input  seg, dp, dig, frame_done
    );
    modport slave (
        input  value, dp_mask, load, blank_lz, brightness, seginv,
        output seg, dp, dig, frame_done
    );
endinterface

// File: rtl/seg_mux_display.sv
// seg_mux_display: multiplexed 7-segment scanner with double-buffered values, blank gap, PWM dimming and LZ blanking.
module seg_mux_display #(
    parameter int CLK_KHZ      = 100,
    parameter int DIGIT_US     = 1000,
    parameter int DIGITS       = 2,
    parameter int BLANK_CYCLES = 2
) (
    input logic              clk,
    input logic              rst_n,
    seg_mux_display_if.slave bus
);
    localparam int DWELL = CLK_KHZ * DIGIT_US / 1000;
    localparam int CW    = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam int IW    = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    generate
        if (DWELL <= BLANK_CYCLES) begin : g_bad_blank
            $error("seg_mux_display: dwell must exceed BLANK_CYCLES");
        end
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("seg_mux_display: DIGITS must be 1..8");
        end
    endgenerate
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          pwm_q, pwm_d;
    logic [4*DIGITS-1:0] active_q, active_d, shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d, fd_q, fd_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic [DIGITS-1:0]   lz;
    logic                seen, wrap, boundary, on, hide;
    logic [3:0]          nib;
    always_comb begin
        wrap     = cnt_q == CW'(DWELL - 1);
        boundary = wrap && idx_q == IW'(DIGITS - 1);
        lz       = '0;
        seen     = 1'b0;
        // walk down from the top digit; a digit is a leading zero until a nonzero nibble is seen
        for (int i = DIGITS - 1; i > 0; i--) begin
            seen  = seen | (active_q[4*i +: 4] != 4'd0);
            lz[i] = ~seen;
        end
        nib       = active_q[4*idx_q +: 4];
        on        = cnt_q >= CW'(BLANK_CYCLES) && pwm_q < bus.brightness;
        hide      = bus.blank_lz && lz[idx_q];
        seg_d     = (on && !hide ? SEG_LUT[nib] : 7'h00) ^ {7{bus.seginv}};
        dp_d      = (on && bus.dp_mask[idx_q]) ^ bus.seginv;
        dig_d     = on ? DIGITS'(1) << idx_q : '0;
        fd_d      = boundary;
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        idx_d     = wrap ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
        pwm_d     = pwm_q == 4'd14 ? 4'd0 : pwm_q + 4'd1;
        shadow_d  = bus.load ? bus.value : shadow_q;
        // a load on the boundary cycle bypasses the shadow so it still makes the next frame
        active_d  = boundary && (pending_q || bus.load) ? (bus.load ? bus.value : shadow_q) : active_q;
        pending_d = !boundary && (pending_q || bus.load);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pwm_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            dig_q     <= '0;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pwm_q     <= pwm_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            dig_q     <= dig_d;
            fd_q      <= fd_d;
        end
    end
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.dig        = dig_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_mux_display.sv
// tb_seg_mux_display: directed steps with a per-cycle scoreboard plus constant spot checks.
module tb_seg_mux_display;
    localparam int DWELL = 100;
    localparam int FRAME = 200;
    localparam int BLANK = 2;
    localparam logic [6:0] CODE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    seg_mux_display_if #(.DIGITS(2)) bus ();
    seg_mux_display #(
        .CLK_KHZ(100), .DIGIT_US(1000), .DIGITS(2), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    int checks = 0;
    int failures = 0;
    int pos = 0;
    logic [10:0] sb[$];
    int m_cnt, m_idx, m_pwm;
    logic [7:0] m_act, m_sh;
    logic m_pend;
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // reference: predicts the pins after the coming edge from state and inputs now
    task automatic model();
        int top;
        logic lit, bnd;
        logic [6:0] s;
        if (!rst_n) begin
            m_cnt = 0; m_idx = 0; m_pwm = 0; m_act = 0; m_sh = 0; m_pend = 0;
            sb.push_back('0);
            return;
        end
        top = 0;
        for (int i = 1; i < 2; i++) if (m_act[4*i +: 4] != 4'd0) top = i;
        lit = m_cnt >= BLANK && m_pwm < int'(bus.brightness);
        s = (lit && !(bus.blank_lz && m_idx > top)) ? CODE[m_act[4*m_idx +: 4]] : 7'h00;
        if (bus.seginv) s = ~s;
        bnd = m_cnt == DWELL - 1 && m_idx == 1;
        sb.push_back({s, (lit && bus.dp_mask[m_idx]) ^ bus.seginv, lit ? 2'(1 << m_idx) : 2'b00, bnd});
        if (bnd) begin
            if (bus.load) m_act = bus.value;
            else if (m_pend) m_act = m_sh;
            m_pend = 0;
        end else if (bus.load) m_pend = 1;
        if (bus.load) m_sh = bus.value;
        m_pwm = (m_pwm + 1) % 15;
        m_cnt++;
        if (m_cnt == DWELL) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 2;
        end
    endtask
    task automatic tick();
        logic [10:0] e;
        model();
        @(posedge clk);
        #1;
        pos = rst_n ? pos + 1 : 0;
        e = sb.pop_front();
        chk("scoreboard", {5'd0, bus.seg, bus.dp, bus.dig, bus.frame_done}, {5'd0, e});
    endtask
    task automatic goto(input int o);
        do tick(); while (((pos - 1) % FRAME) != o);
    endtask
    task automatic do_load(input logic [7:0] v);
        bus.value = v;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask
    initial begin
        int n, ex, st;
        bus.value = 8'h00; bus.dp_mask = 2'b00; bus.load = 1'b0;
        bus.blank_lz = 1'b0; bus.brightness = 4'd15; bus.seginv = 1'b0;
        tick(); tick();
        chk("reset_outputs", {5'd0, bus.seg, bus.dp, bus.dig, bus.frame_done}, 16'h0);
        #2 rst_n = 1'b1;
        pos = 0;
        tick(); tick();
        chk("t1_blank_gap", 16'(bus.dig), 16'h0);
        tick();
        chk("t1_dig0_on", 16'(bus.dig), 16'h1);
        chk("t1_seg0_zero", 16'(bus.seg), 16'h3F);
        goto(102);
        chk("t1_dig1_on", 16'(bus.dig), 16'h2);
        chk("t1_seg1_zero", 16'(bus.seg), 16'h3F);
        goto(199);
        chk("t1_fd_pulse", 16'(bus.frame_done), 16'h1);
        n = 0;
        do begin tick(); n++; end while (!bus.frame_done && n < 500);
        chk("t1_fd_period", 16'(n), 16'd200);
        goto(50);
        do_load(8'h3A);
        goto(60);
        chk("t2_no_early", 16'(bus.seg), 16'h3F);
        goto(199);
        goto(60);
        chk("t2_dig0_A", 16'(bus.seg), 16'h77);
        goto(160);
        chk("t2_dig1_3", 16'(bus.seg), 16'h4F);
        goto(20);
        do_load(8'h3A);
        goto(120);
        do_load(8'h11);
        goto(60);
        chk("t2_last_wins0", 16'(bus.seg), 16'h06);
        goto(160);
        chk("t2_last_wins1", 16'(bus.seg), 16'h06);
        goto(198);
        do_load(8'h25);
        goto(60);
        chk("t2_bnd_load0", 16'(bus.seg), 16'h6D);
        goto(160);
        chk("t2_bnd_load1", 16'(bus.seg), 16'h5B);
        bus.blank_lz = 1'b1;
        bus.dp_mask = 2'b10;
        goto(100);
        do_load(8'h07);
        goto(199);
        goto(150);
        chk("t3_lz_dig", 16'(bus.dig), 16'h2);
        chk("t3_lz_seg", 16'(bus.seg), 16'h00);
        chk("t3_lz_dp", 16'(bus.dp), 16'h1);
        goto(50);
        chk("t3_d0_seg", 16'(bus.seg), 16'h07);
        chk("t3_d0_dp", 16'(bus.dp), 16'h0);
        goto(100);
        do_load(8'h00);
        goto(50);
        chk("t3_zero_d0", 16'(bus.seg), 16'h3F);
        goto(150);
        chk("t3_zero_d1", 16'(bus.seg), 16'h00);
        bus.blank_lz = 1'b0;
        bus.dp_mask = 2'b00;
        do_load(8'h88);
        goto(199);
        bus.brightness = 4'd5;
        n = 0; ex = 0;
        for (int k = 0; k < DWELL; k++) begin
            tick();
            st = pos - 1;
            if (bus.dig != 2'b00) n++;
            if (st % DWELL >= BLANK && st % 15 < 5) ex++;
        end
        chk("t4_duty5", 16'(n), 16'(ex));
        bus.brightness = 4'd0;
        goto(199);
        n = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (bus.dig != 2'b00) n++;
        end
        chk("t4_off", 16'(n), 16'd0);
        bus.brightness = 4'd15;
        bus.seginv = 1'b1;
        do_load(8'h08);
        goto(199);
        goto(0);
        chk("t5_gap0", {5'd0, bus.seg, bus.dp, bus.dig, bus.frame_done}, {5'd0, 7'h7F, 1'b1, 2'b00, 1'b0});
        goto(1);
        chk("t5_gap1", {8'd0, bus.seg, bus.dp}, {8'd0, 7'h7F, 1'b1});
        goto(50);
        chk("t5_inv8", {5'd0, bus.seg, bus.dp, bus.dig, bus.frame_done}, {5'd0, 7'h00, 1'b1, 2'b01, 1'b0});
        bus.seginv = 1'b0;
        goto(140);
        do_load(8'h55);
        goto(160);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async", {5'd0, bus.seg, bus.dp, bus.dig, bus.frame_done}, 16'h0);
        tick(); tick();
        #2 rst_n = 1'b1;
        pos = 0;
        goto(50);
        chk("t6_restart_dig", 16'(bus.dig), 16'h1);
        chk("t6_restart_seg", 16'(bus.seg), 16'h3F);
        goto(199);
        goto(50);
        chk("t6_pend_drop0", 16'(bus.seg), 16'h3F);
        goto(150);
        chk("t6_pend_drop1", 16'(bus.seg), 16'h3F);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
